// File: rtl/spike_uart_tx.sv
// spike_uart_tx: periodic UART streamer for a multi-channel spike snapshot.
// Captures NUM_CH channel bits at the start of every period, sends them as
// ceil(NUM_CH/DATA_BITS) framed UART characters (LSB channel first, optional
// even parity), then holds the line at mark for IDLE_BITS bit times.
// All outputs are registered from the current state, so the line lags the
// state register by exactly one cycle and every level lasts CLKS_PER_BIT cycles.
module spike_uart_tx #(
  parameter int unsigned NUM_CH       = 18,
  parameter int unsigned DATA_BITS    = 6,
  parameter int unsigned CLKS_PER_BIT = 20833,
  parameter int unsigned IDLE_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STICKY       = 0
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              uart_start,
  input  logic [NUM_CH-1:0] ch_in,
  output logic              uart_txd,
  output logic              busy,
  output logic              frame_done,
  output logic              period_done
);

  // Derived geometry: frames per period and the zero-padded snapshot width.
  localparam int unsigned NUM_FRAMES = (NUM_CH + DATA_BITS - 1) / DATA_BITS;
  localparam int unsigned SNAP_W     = NUM_FRAMES * DATA_BITS;

  // Counter widths: bit-time timer, in-frame/gap bit counter, frame index.
  localparam int unsigned TMR_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CNT_MAX = (DATA_BITS > IDLE_BITS) ? DATA_BITS : IDLE_BITS;
  localparam int unsigned BIT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned FRM_W   = $clog2(NUM_FRAMES + 1);

  // Terminal counts, pre-sized to their counters.
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] GAP_LAST  = BIT_W'(IDLE_BITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(NUM_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_e;

  state_e            state_q,  state_d;
  logic [TMR_W-1:0]  tmr_q,    tmr_d;
  logic [BIT_W-1:0]  bit_q,    bit_d;
  logic [FRM_W-1:0]  frm_q,    frm_d;
  logic [NUM_CH-1:0] snap_q,   snap_d;
  logic [NUM_CH-1:0] acc_q,    acc_d;
  logic              txd_q,    txd_d;
  logic              busy_q,   busy_d;
  logic              fdone_q,  fdone_d;
  logic              pdone_q,  pdone_d;

  logic                 tick;
  logic [SNAP_W-1:0]    snap_pad;
  logic [DATA_BITS-1:0] frame_data;
  logic                 cur_bit;
  logic                 parity_bit;
  logic [NUM_CH-1:0]    capture;

  // Last cycle of the current bit time.
  assign tick = (tmr_q == TMR_LAST);

  // Channels beyond NUM_CH in the final frame transmit as zero.
  assign snap_pad = SNAP_W'(snap_q);

  // Value loaded into the snapshot: held spikes plus this cycle's, or just this cycle's.
  assign capture = (STICKY != 0) ? (acc_q | ch_in) : ch_in;

  // Select the payload of the frame currently being sent.
  always_comb begin
    frame_data = '0;
    for (int unsigned f = 0; f < NUM_FRAMES; f++) begin
      if (frm_q == FRM_W'(f)) begin
        frame_data = snap_pad[f*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Current data bit (LSB first) and even parity over the frame payload.
  assign cur_bit    = |(frame_data & (DATA_BITS'(1) << bit_q));
  assign parity_bit = ^frame_data;

  // Next-state, counters, snapshot/accumulator and registered-output values.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    frm_d   = frm_q;
    snap_d  = snap_q;
    acc_d   = (STICKY != 0) ? (acc_q | ch_in) : '0;
    txd_d   = 1'b1;
    busy_d  = (state_q != S_IDLE);
    fdone_d = 1'b0;
    pdone_d = 1'b0;

    // Bit timer free-runs 0..CLKS_PER_BIT-1 whenever a period is active.
    if (state_q == S_IDLE) begin
      tmr_d = '0;
    end else if (tick) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + TMR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        bit_d = '0;
        frm_d = '0;
        acc_d = '0;
        if (uart_start) begin
          state_d = S_START;
          snap_d  = capture;
          acc_d   = '0;
        end
      end

      S_START: begin
        txd_d = 1'b0;
        if (tick) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end

      S_DATA: begin
        txd_d = cur_bit;
        if (tick) begin
          if (bit_q == DATA_LAST) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      S_PARITY: begin
        txd_d = parity_bit;
        if (tick) begin
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        txd_d = 1'b1;
        if (tick) begin
          fdone_d = 1'b1;
          bit_d   = '0;
          if (frm_q == FRM_LAST) begin
            state_d = S_GAP;
          end else begin
            state_d = S_START;
            frm_d   = frm_q + FRM_W'(1);
          end
        end
      end

      S_GAP: begin
        txd_d = 1'b1;
        if (tick) begin
          if (bit_q == GAP_LAST) begin
            pdone_d = 1'b1;
            bit_d   = '0;
            frm_d   = '0;
            if (uart_start) begin
              state_d = S_START;
              snap_d  = capture;
              acc_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      frm_q   <= '0;
      snap_q  <= '0;
      acc_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      pdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      frm_q   <= frm_d;
      snap_q  <= snap_d;
      acc_q   <= acc_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
      pdone_q <= pdone_d;
    end
  end

  assign uart_txd    = txd_q;
  assign busy        = busy_q;
  assign frame_done  = fdone_q;
  assign period_done = pdone_q;

endmodule
